// File: rtl/timerio_pkg.sv
// Register offsets and CTRL bit positions shared by the interval timer and its bench-facing users.
package timerio_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_STATUS   = 3'd1;
    localparam logic [2:0] TMR_RELOAD_H = 3'd2;
    localparam logic [2:0] TMR_RELOAD_L = 3'd3;
    localparam logic [2:0] TMR_COUNT_H  = 3'd4;
    localparam logic [2:0] TMR_COUNT_L  = 3'd5;
    localparam logic [2:0] TMR_PRESCALE = 3'd6;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQEN    = 2;

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: counts down while enabled and emits a one-cycle tick on the cycle pc==0,
// reloading from load_val at that point; load forces a reload with no tick.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       tick
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        tick = 1'b0;
        if (load) begin
            pc_d = load_val;
        end else if (en) begin
            if (pc_q == 8'd0) begin
                tick = 1'b1;
                pc_d = load_val;
            end else begin
                pc_d = pc_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 8'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/timerio.sv
// 16-bit interval timer on the 6801 peripheral bus: one-shot or periodic, prescaled by pc,
// level irq = ZF & IRQEN; DO is combinational from AD, register writes land on the cs&&!rw edge.
module timerio
    import timerio_pkg::*;
#(
    parameter logic [15:0] RELOAD_RST   = 16'hFFFF,
    parameter logic [7:0]  PRESCALE_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs
);

    logic        en_q, en_d;
    logic        periodic_q, periodic_d;
    logic        irqen_q, irqen_d;
    logic        zf_q, zf_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  hold_h_q, hold_h_d;
    logic [7:0]  latch_l_q, latch_l_d;

    logic bus_wr, bus_rd, ctrl_wr, start, run, tick, zf_set;

    assign bus_wr  = cs && !rw;
    assign bus_rd  = cs && rw;
    assign ctrl_wr = bus_wr && (AD == TMR_CTRL);
    assign start   = ctrl_wr && DI[CTRL_EN] && !en_q;
    // A CTRL write clearing EN freezes count and pc on that very edge.
    assign run     = en_q && !(ctrl_wr && !DI[CTRL_EN]);
    assign zf_set  = tick && (count_q == 16'd0);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .en       (run),
        .load_val (prescale_q),
        .tick     (tick)
    );

    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        irqen_d    = irqen_q;
        zf_d       = zf_q;
        reload_d   = reload_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        hold_h_d   = hold_h_q;
        latch_l_d  = latch_l_q;

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                zf_d = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
        if (start) begin
            count_d = reload_q;
        end

        // Bus writes come after the tick so a CTRL write overrides one-shot expiry.
        if (bus_wr) begin
            case (AD)
                TMR_CTRL: begin
                    en_d       = DI[CTRL_EN];
                    periodic_d = DI[CTRL_PERIODIC];
                    irqen_d    = DI[CTRL_IRQEN];
                end
                TMR_STATUS: begin
                    if (DI[0] && !zf_set) begin
                        zf_d = 1'b0;
                    end
                end
                TMR_RELOAD_H: hold_h_d   = DI;
                TMR_RELOAD_L: reload_d   = {hold_h_q, DI};
                TMR_PRESCALE: prescale_d = DI;
                default: ;
            endcase
        end
        if (bus_rd && (AD == TMR_COUNT_H)) begin
            latch_l_d = count_q[7:0];
        end
    end

    always_comb begin
        DO = 8'h00;
        if (cs) begin
            case (AD)
                TMR_CTRL:     DO = {5'b0, irqen_q, periodic_q, en_q};
                TMR_STATUS:   DO = {6'b0, en_q, zf_q};
                TMR_RELOAD_H: DO = reload_q[15:8];
                TMR_RELOAD_L: DO = reload_q[7:0];
                TMR_COUNT_H:  DO = count_q[15:8];
                TMR_COUNT_L:  DO = latch_l_q;
                TMR_PRESCALE: DO = prescale_q;
                default:      DO = 8'h00;
            endcase
        end
    end

    assign irq = zf_q & irqen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irqen_q    <= 1'b0;
            zf_q       <= 1'b0;
            reload_q   <= RELOAD_RST;
            count_q    <= 16'd0;
            prescale_q <= PRESCALE_RST;
            hold_h_q   <= 8'd0;
            latch_l_q  <= 8'd0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irqen_q    <= irqen_d;
            zf_q       <= zf_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            hold_h_q   <= hold_h_d;
            latch_l_q  <= latch_l_d;
        end
    end

endmodule

// File: tb/tb_timerio.sv
// Directed bench for timerio: inputs change and outputs are sampled on the falling edge,
// so every bus access owns exactly one rising edge.
module tb_timerio;

    logic       clk;
    logic       rst;
    logic       irq;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    int checks   = 0;
    int failures = 0;

    timerio dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1;
        d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (irq !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp_r [8];
        exp_r = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL reset_irq got=%b want=0", irq); failures++;
        end
        cs = 1'b0; AD = 3'd2;
        #1;
        checks++;
        if (DO !== 8'h00) begin
            $display("FAIL reset_do_cs0 got=%h want=00", DO); failures++;
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++;
            if (v !== exp_r[i]) begin
                $display("FAIL reset_reg%0d got=%h want=%h", i, v, exp_r[i]); failures++;
            end
        end
    endtask

    task automatic test_oneshot();
        int n;
        logic [7:0] v;
        logic [7:0] lo;
        do_reset();
        wr(3'd2, 8'h00); wr(3'd3, 8'h04); wr(3'd6, 8'h01); wr(3'd0, 8'h05);
        wait_irq(n);
        checks++;
        if (n !== 10) begin
            $display("FAIL oneshot_latency got=%0d want=10", n); failures++;
        end
        rd(3'd1, v);
        checks++;
        if (v !== 8'h01) begin
            $display("FAIL oneshot_status got=%h want=01", v); failures++;
        end
        rd(3'd0, v);
        checks++;
        if (v !== 8'h04) begin
            $display("FAIL oneshot_ctrl got=%h want=04", v); failures++;
        end
        rd(3'd4, v);
        rd(3'd5, lo);
        checks++;
        if ({v, lo} !== 16'h0000) begin
            $display("FAIL oneshot_count got=%h want=0000", {v, lo}); failures++;
        end
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL oneshot_irq_hold got=%b want=1", irq); failures++;
        end
    endtask

    task automatic test_periodic();
        int n;
        do_reset();
        wr(3'd2, 8'h00); wr(3'd3, 8'h02); wr(3'd6, 8'h00); wr(3'd0, 8'h07);
        wait_irq(n);
        checks++;
        if (n !== 3) begin
            $display("FAIL periodic_first got=%0d want=3", n); failures++;
        end
        for (int p = 0; p < 3; p++) begin
            wr(3'd1, 8'h01);
            checks++;
            if (irq !== 1'b0) begin
                $display("FAIL periodic_clear%0d got=%b want=0", p, irq); failures++;
            end
            wait_irq(n);
            checks++;
            if (n !== 2) begin
                $display("FAIL periodic_reassert%0d got=%0d want=2", p, n); failures++;
            end
        end
    endtask

    task automatic test_coherent_read();
        logic [7:0] hi;
        logic [7:0] lo;
        do_reset();
        wr(3'd2, 8'h01); wr(3'd3, 8'h00); wr(3'd6, 8'h00); wr(3'd0, 8'h01);
        repeat (3) @(negedge clk);
        rd(3'd4, hi);
        repeat (4) @(negedge clk);
        rd(3'd5, lo);
        checks++;
        if ({hi, lo} !== 16'h00FD) begin
            $display("FAIL coherent_count got=%h want=00fd", {hi, lo}); failures++;
        end
    endtask

    task automatic test_collision();
        logic [7:0] v;
        do_reset();
        wr(3'd2, 8'h00); wr(3'd3, 8'h02); wr(3'd6, 8'h00); wr(3'd0, 8'h07);
        repeat (2) @(negedge clk);
        wr(3'd1, 8'h01);
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL collision_irq got=%b want=1", irq); failures++;
        end
        rd(3'd1, v);
        checks++;
        if (v !== 8'h03) begin
            $display("FAIL collision_status got=%h want=03", v); failures++;
        end
        wr(3'd1, 8'h01);
        rd(3'd1, v);
        checks++;
        if (v !== 8'h02) begin
            $display("FAIL collision_plain_clear got=%h want=02", v); failures++;
        end
    endtask

    task automatic test_pause_restart();
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] v;
        do_reset();
        wr(3'd2, 8'h01); wr(3'd3, 8'h00); wr(3'd6, 8'h00); wr(3'd0, 8'h01);
        repeat (128) @(negedge clk);
        wr(3'd0, 8'h00);
        repeat (20) @(negedge clk);
        rd(3'd4, hi);
        rd(3'd5, lo);
        checks++;
        if ({hi, lo} !== 16'h0080) begin
            $display("FAIL pause_count got=%h want=0080", {hi, lo}); failures++;
        end
        rd(3'd1, v);
        checks++;
        if (v !== 8'h00) begin
            $display("FAIL pause_status got=%h want=00", v); failures++;
        end
        wr(3'd0, 8'h01);
        rd(3'd4, hi);
        rd(3'd5, lo);
        checks++;
        if ({hi, lo} !== 16'h0100) begin
            $display("FAIL restart_count got=%h want=0100", {hi, lo}); failures++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] v;
        logic [7:0] exp_r [8];
        exp_r = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        wr(3'd2, 8'h00); wr(3'd3, 8'h02); wr(3'd6, 8'h03); wr(3'd0, 8'h07);
        wait_irq(n);
        checks++;
        if (n !== 12) begin
            $display("FAIL midreset_period got=%0d want=12", n); failures++;
        end
        wr(3'd2, 8'hAB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL midreset_irq got=%b want=0", irq); failures++;
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++;
            if (v !== exp_r[i]) begin
                $display("FAIL midreset_reg%0d got=%h want=%h", i, v, exp_r[i]); failures++;
            end
        end
        wr(3'd3, 8'h34);
        rd(3'd2, v);
        checks++;
        if (v !== 8'h00) begin
            $display("FAIL midreset_hold_h got=%h want=00", v); failures++;
        end
        rd(3'd3, v);
        checks++;
        if (v !== 8'h34) begin
            $display("FAIL midreset_reload_l got=%h want=34", v); failures++;
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'd0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_coherent_read();
        test_collision();
        test_pause_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
